// File: rtl/fft2d_corner_turn_ctrl.sv
// -----------------------------------------------------------------------------
// fft2d_corner_turn_ctrl
//
// Corner-turn controller sitting between the row-FFT and column-FFT stages.
// It writes an N x N frame of complex words in row-major order through RAM
// port 0 and reads it back in column-major (transposed) order through RAM
// port 1. The RAM is split into two banks (address MSB) used as a ping-pong
// pair, so one frame can be written while the previous one is read out.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   row-major input stream handshake, in_data payload
//   out_valid/out_ready column-major output stream handshake,
//                       out_data payload, out_last on the final word of a frame
//   address_0, data_0   RAM port 0 (write only); data_0 driven only on a write
//   cs_0, we_0, oe_0    RAM port 0 controls
//   address_1, data_1   RAM port 1 (read only); data_1 never driven here
//   cs_1, we_1, oe_1    RAM port 1 controls
// -----------------------------------------------------------------------------
module fft2d_corner_turn_ctrl #(
   parameter int DATA_W   = 32,
   parameter int DIM_BITS = 3,
   parameter int ADDR_W   = 2*DIM_BITS+1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [ADDR_W-1:0] address_0,
   inout  wire  [DATA_W-1:0] data_0,
   output logic              cs_0,
   output logic              we_0,
   output logic              oe_0,
   output logic [ADDR_W-1:0] address_1,
   inout  wire  [DATA_W-1:0] data_1,
   output logic              cs_1,
   output logic              we_1,
   output logic              oe_1
);

   localparam int               CNT_W    = 2*DIM_BITS;
   localparam logic [CNT_W-1:0] CNT_LAST = '1;

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic                         wr_bank_q, wr_bank_d;
   logic [CNT_W-1:0]             wr_cnt_q,  wr_cnt_d;
   logic                         rd_bank_q, rd_bank_d;
   logic [CNT_W-1:0]             rd_cnt_q,  rd_cnt_d;
   logic [1:0]                   full_q,    full_d;
   logic                         rd_pend_q, rd_pend_d;
   logic                         rd_pend_last_q, rd_pend_last_d;

   // 2-entry output FIFO
   logic [1:0][DATA_W-1:0]       fifo_data_q, fifo_data_d;
   logic [1:0]                   fifo_last_q, fifo_last_d;
   logic                         fifo_wp_q,   fifo_wp_d;
   logic                         fifo_rp_q,   fifo_rp_d;
   logic [1:0]                   fifo_cnt_q,  fifo_cnt_d;

   // --------------------------------------------------------------------------
   // Write side
   // --------------------------------------------------------------------------
   logic wr_acc;
   logic wr_end;

   // rst_n gates in_ready so nothing is accepted while reset is held.
   assign in_ready = rst_n & ~full_q[wr_bank_q];
   assign wr_acc   = in_valid & in_ready;
   assign wr_end   = wr_acc & (wr_cnt_q == CNT_LAST);

   assign cs_0      = wr_acc;
   assign we_0      = wr_acc;
   assign oe_0      = 1'b0;
   assign address_0 = wr_acc ? {wr_bank_q, wr_cnt_q} : '0;
   assign data_0    = (cs_0 & we_0) ? in_data : {DATA_W{1'bz}};

   always_comb begin
      wr_cnt_d  = wr_cnt_q;
      wr_bank_d = wr_bank_q;
      if (wr_acc) begin
         wr_cnt_d = wr_cnt_q + 1'b1;   // wraps to 0 after the last index
      end
      if (wr_end) begin
         wr_bank_d = ~wr_bank_q;
      end
   end

   // --------------------------------------------------------------------------
   // Read side
   // --------------------------------------------------------------------------
   logic                rd_issue;
   logic                rd_end;
   logic [2:0]          in_flight;
   logic [DIM_BITS-1:0] rd_row;
   logic [DIM_BITS-1:0] rd_col;

   // Words buffered plus the one the RAM is currently returning; never let
   // this exceed the FIFO depth so a stalled consumer cannot cause overflow.
   assign in_flight = {1'b0, fifo_cnt_q} + {2'b00, rd_pend_q};
   assign rd_issue  = full_q[rd_bank_q] & (in_flight < 3'd2);
   assign rd_end    = rd_issue & (rd_cnt_q == CNT_LAST);

   // Low counter bits step the row, high bits the column: transposed order.
   assign rd_row    = rd_cnt_q[DIM_BITS-1:0];
   assign rd_col    = rd_cnt_q[CNT_W-1:DIM_BITS];

   assign address_1 = rd_issue ? {rd_bank_q, rd_row, rd_col} : '0;
   // Keep cs/oe high during the return cycle so the RAM drives its bus.
   assign cs_1      = rd_issue | rd_pend_q;
   assign oe_1      = rd_issue | rd_pend_q;
   assign we_1      = 1'b0;

   always_comb begin
      rd_cnt_d       = rd_cnt_q;
      rd_bank_d      = rd_bank_q;
      rd_pend_d      = rd_issue;
      rd_pend_last_d = rd_end;
      if (rd_issue) begin
         rd_cnt_d = rd_cnt_q + 1'b1;
      end
      if (rd_end) begin
         rd_bank_d = ~rd_bank_q;
      end
   end

   // Full flags: a bank is released as soon as its last address is issued;
   // the RAM has latched that address, so the writer may reuse the bank.
   always_comb begin
      full_d = full_q;
      if (wr_end) begin
         full_d[wr_bank_q] = 1'b1;
      end
      if (rd_end) begin
         full_d[rd_bank_q] = 1'b0;
      end
   end

   // --------------------------------------------------------------------------
   // Output FIFO
   // --------------------------------------------------------------------------
   logic fifo_push;
   logic fifo_pop;

   assign out_valid = (fifo_cnt_q != 2'd0);
   assign out_data  = out_valid ? fifo_data_q[fifo_rp_q] : '0;
   assign out_last  = out_valid & fifo_last_q[fifo_rp_q];

   assign fifo_push = rd_pend_q;
   assign fifo_pop  = out_valid & out_ready;

   always_comb begin
      fifo_data_d = fifo_data_q;
      fifo_last_d = fifo_last_q;
      fifo_wp_d   = fifo_wp_q;
      fifo_rp_d   = fifo_rp_q;
      fifo_cnt_d  = fifo_cnt_q;
      if (fifo_push) begin
         fifo_data_d[fifo_wp_q] = data_1;
         fifo_last_d[fifo_wp_q] = rd_pend_last_q;
         fifo_wp_d              = ~fifo_wp_q;
      end
      if (fifo_pop) begin
         fifo_rp_d = ~fifo_rp_q;
      end
      case ({fifo_push, fifo_pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
         2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
   end

   // --------------------------------------------------------------------------
   // Registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bank_q      <= 1'b0;
         wr_cnt_q       <= '0;
         rd_bank_q      <= 1'b0;
         rd_cnt_q       <= '0;
         full_q         <= 2'b00;
         rd_pend_q      <= 1'b0;
         rd_pend_last_q <= 1'b0;
         fifo_data_q    <= '0;
         fifo_last_q    <= 2'b00;
         fifo_wp_q      <= 1'b0;
         fifo_rp_q      <= 1'b0;
         fifo_cnt_q     <= 2'd0;
      end else begin
         wr_bank_q      <= wr_bank_d;
         wr_cnt_q       <= wr_cnt_d;
         rd_bank_q      <= rd_bank_d;
         rd_cnt_q       <= rd_cnt_d;
         full_q         <= full_d;
         rd_pend_q      <= rd_pend_d;
         rd_pend_last_q <= rd_pend_last_d;
         fifo_data_q    <= fifo_data_d;
         fifo_last_q    <= fifo_last_d;
         fifo_wp_q      <= fifo_wp_d;
         fifo_rp_q      <= fifo_rp_d;
         fifo_cnt_q     <= fifo_cnt_d;
      end
   end

endmodule

// File: tb/tb_fft2d_corner_turn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft2d_corner_turn_ctrl
//
// Drives fft2d_corner_turn_ctrl against a two-port RAM model with a one-cycle
// registered read that drives its bus only while cs&oe are high. A released
// bus reads as all ones (tri1 nets). Outputs are compared against a queue of
// column-major words computed from the frame base value.
// -----------------------------------------------------------------------------
module tb_fft2d_corner_turn_ctrl;

   localparam int DW = 32;
   localparam int DB = 3;
   localparam int AW = 2*DB+1;
   localparam int NN = 64;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic [AW-1:0] address_0;
   logic [AW-1:0] address_1;
   logic          cs_0, we_0, oe_0;
   logic          cs_1, we_1, oe_1;
   tri1  [DW-1:0] data_0;
   tri1  [DW-1:0] data_1;

   fft2d_corner_turn_ctrl #(.DATA_W(DW), .DIM_BITS(DB), .ADDR_W(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .address_0 (address_0),
      .data_0    (data_0),
      .cs_0      (cs_0),
      .we_0      (we_0),
      .oe_0      (oe_0),
      .address_1 (address_1),
      .data_1    (data_1),
      .cs_1      (cs_1),
      .we_1      (we_1),
      .oe_1      (oe_1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM model
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] ram_q;
   logic          ram_vld;

   initial ram_vld = 1'b0;

   always @(posedge clk) begin
      if (cs_0 && we_0) mem[address_0] <= data_0;
      ram_vld <= cs_1 & oe_1 & ~we_1;
      if (cs_1 && oe_1 && !we_1) ram_q <= mem[address_1];
   end

   assign data_1 = (cs_1 && oe_1 && ram_vld) ? ram_q : {DW{1'bz}};

   // Bench state
   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
   } exp_t;

   typedef struct {
      logic          rst;
      logic          iv;
      logic [DW-1:0] din;
      logic          rdy;
      logic [5:0]    ctl;   // {cs_0,we_0,oe_0,cs_1,we_1,oe_1}
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic          ov;
   } vec_t;

   exp_t exp_q[$];
   vec_t vt[4];
   int   nchk;
   int   nerr;
   int   wb, wi;        // expected write bank / index
   int   or_mode;       // 0: ready, 1: stalled, 2: 1,0,0,1 pattern
   int   or_ph;
   int   cs1_cnt;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      nchk++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s got=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic expect_frame(input int base);
      exp_t e;
      for (int k = 0; k < NN; k++) begin
         e.d = DW'(base + (k % 8) * 8 + k / 8);
         e.l = (k == NN-1);
         exp_q.push_back(e);
      end
   endtask

   // Called just after a falling edge.
   task automatic mon();
      exp_t e;
      if (cs_1) cs1_cnt++;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL out_extra got=%0d required=none", out_data);
         end else begin
            e = exp_q.pop_front();
            chk("out_word", {31'b0, out_last, out_data}, {31'b0, e.l, e.d});
         end
      end
   endtask

   // Called just after a rising edge.
   task automatic drive_or();
      case (or_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'b0;
         default: out_ready = ((or_ph % 4) == 0) || ((or_ph % 4) == 3);
      endcase
      or_ph++;
   endtask

   task automatic tick();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
      drive_or();
   endtask

   task automatic push_words(input int start, input int n, input int maxcyc,
                             output int acc, output int stalls);
      int v;
      int cyc;
      logic ok;
      logic [AW-1:0] ea;
      v = start; cyc = 0; acc = 0; stalls = 0;
      while (acc < n && cyc < maxcyc) begin
         in_valid = 1'b1;
         in_data  = DW'(v);
         @(negedge clk);
         mon();
         ok = in_ready;
         if (ok) begin
            ea = {wb[0], wi[5:0]};
            chk("addr0", 64'(address_0), 64'(ea));
            chk("data0", 64'(data_0), 64'(v));
            chk("ctl0", {60'b0, cs_0, we_0, oe_0, we_1}, 64'b1100);
         end else begin
            stalls++;
         end
         @(posedge clk);
         #1;
         drive_or();
         cyc++;
         if (ok) begin
            acc++;
            v++;
            wi++;
            if (wi == NN) begin
               wi = 0;
               wb = wb ^ 1;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input int maxcyc);
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < maxcyc) begin
         tick();
         c++;
      end
      repeat (4) tick();
      chk("drain_left", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int acc, st, n, cs0;
      nchk = 0; nerr = 0; wb = 0; wi = 0;
      or_mode = 0; or_ph = 0; cs1_cnt = 0;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

      // ---------------- reset / idle vectors ----------------
      vt[0] = '{rst:1'b0, iv:1'b1, din:32'h11, rdy:1'b0, ctl:6'b000000,
                a0:'0, a1:'0, d0:'1, d1:'1, ov:1'b0};
      vt[1] = '{rst:1'b0, iv:1'b0, din:32'h22, rdy:1'b0, ctl:6'b000000,
                a0:'0, a1:'0, d0:'1, d1:'1, ov:1'b0};
      vt[2] = '{rst:1'b1, iv:1'b0, din:32'h33, rdy:1'b1, ctl:6'b000000,
                a0:'0, a1:'0, d0:'1, d1:'1, ov:1'b0};
      vt[3] = '{rst:1'b1, iv:1'b1, din:32'h5A, rdy:1'b1, ctl:6'b110000,
                a0:'0, a1:'0, d0:32'h5A, d1:'1, ov:1'b0};

      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         rst_n    = vt[i].rst;
         in_valid = vt[i].iv;
         in_data  = vt[i].din;
         #1;
         chk("vec_in_ready", 64'(in_ready), 64'(vt[i].rdy));
         chk("vec_ctl", 64'({cs_0, we_0, oe_0, cs_1, we_1, oe_1}), 64'(vt[i].ctl));
         chk("vec_addr0", 64'(address_0), 64'(vt[i].a0));
         chk("vec_addr1", 64'(address_1), 64'(vt[i].a1));
         chk("vec_data0", 64'(data_0), 64'(vt[i].d0));
         chk("vec_data1", 64'(data_1), 64'(vt[i].d1));
         chk("vec_out", {31'b0, out_valid, out_last, out_data}, {31'b0, vt[i].ov, 1'b0, 32'h0});
         in_valid = 1'b0;   // never let a vector cross a clock edge
         @(posedge clk);
         #1;
      end

      // ---------------- single frame + latency ----------------
      expect_frame(0);
      push_words(0, NN, 200, acc, st);
      chk("f1_accepts", 64'(acc), 64'(NN));
      n = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         mon();
         if (out_valid) break;
         @(posedge clk);
         #1;
         drive_or();
         n++;
      end
      @(posedge clk);
      #1;
      drive_or();
      chk("latency_edges", 64'(n), 64'd2);
      wait_drain(1000);

      // ---------------- two back-to-back frames ----------------
      expect_frame(0);
      expect_frame(64);
      push_words(0, 2*NN, 400, acc, st);
      chk("b2b_accepts", 64'(acc), 64'(2*NN));
      chk("b2b_stalls", 64'(st), 64'd0);
      wait_drain(1000);

      // ---------------- stalled consumer ----------------
      or_mode = 1;
      tick();
      tick();
      expect_frame(0);
      expect_frame(64);
      cs0 = cs1_cnt;
      push_words(0, 200, 260, acc, st);
      chk("stall_accepts", 64'(acc), 64'd128);
      repeat (4) tick();
      chk("stall_cs1_le4", 64'((cs1_cnt - cs0) <= 4), 64'd1);
      chk("stall_cs1_idle", 64'(cs_1), 64'd0);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_head", {31'b0, out_valid, out_data}, {31'b0, 1'b1, 32'd0});
      or_mode = 0;
      wait_drain(1000);
      chk("stall_ready_back", 64'(in_ready), 64'd1);

      // ---------------- toggling out_ready ----------------
      or_mode = 2;
      expect_frame(0);
      expect_frame(64);
      push_words(0, 2*NN, 600, acc, st);
      chk("tog_accepts", 64'(acc), 64'(2*NN));
      wait_drain(2000);
      or_mode = 0;
      tick();

      // ---------------- reset mid-frame ----------------
      push_words(0, 20, 100, acc, st);
      chk("part_accepts", 64'(acc), 64'd20);
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'd77;
      #1;
      chk("mrst_in_ready", 64'(in_ready), 64'd0);
      chk("mrst_ctl", 64'({cs_0, we_0, oe_0, cs_1, we_1, oe_1}), 64'd0);
      chk("mrst_data0", 64'(data_0), 64'hFFFF_FFFF);
      chk("mrst_data1", 64'(data_1), 64'hFFFF_FFFF);
      chk("mrst_out", {31'b0, out_valid, out_last, out_data}, 64'd0);
      in_valid = 1'b0;
      exp_q.delete();
      wb = 0;
      wi = 0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      expect_frame(100);
      push_words(100, NN, 200, acc, st);
      chk("post_rst_accepts", 64'(acc), 64'(NN));
      wait_drain(1000);
      chk("final_idle", {62'b0, out_valid, cs_1}, 64'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
